// File: rtl/y86_decode_stage_pkg.sv
// y86_pkg: shared Y86-64 icodes, register IDs, status codes and parameter defaults.
package y86_pkg;
  localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7;
  localparam logic [3:0] ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [1:0] SAOK = 2'd0, SHLT = 2'd1, SADR = 2'd2, SINS = 2'd3;
  localparam int W_DEF = 64;
  localparam logic [3:0] RSP_DEF = 4'h4;
endpackage

// File: rtl/y86_decode_stage_regfile.sv
// y86_regfile: 2-read/2-write register file, dstM write wins on collision, reads return pre-edge contents.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int NREG = 15
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [3:0]   src_a,
  input  logic [3:0]   src_b,
  output logic [W-1:0] val_a,
  output logic [W-1:0] val_b,
  input  logic [3:0]   dst_e,
  input  logic [3:0]   dst_m,
  input  logic [W-1:0] val_e,
  input  logic [W-1:0] val_m
);
  logic [W-1:0] rf_q [NREG];
  function automatic logic ok(input logic [3:0] id);
    return id != RNONE && 32'(id) < NREG;
  endfunction
  assign val_a = ok(src_a) ? rf_q[src_a] : '0;
  assign val_b = ok(src_b) ? rf_q[src_b] : '0;
  // dstM is written last so it overrides dstE when both target one register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (ok(dst_e)) rf_q[dst_e] <= val_e;
      if (ok(dst_m)) rf_q[dst_m] <= val_m;
    end
  end
endmodule

// File: rtl/y86_decode_stage.sv
// y86_decode_stage: Y86-64 decode/write-back with operand forwarding and the D->E pipeline register.
module y86_decode_stage
  import y86_pkg::*;
#(
  parameter int         W      = W_DEF,
  parameter int         NREG   = 15,
  parameter logic [3:0] RSP_ID = RSP_DEF,
  parameter bit         FWD_EN = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [1:0]   D_stat,
  input  logic [3:0]   D_icode,
  input  logic [3:0]   D_ifun,
  input  logic [3:0]   D_rA,
  input  logic [3:0]   D_rB,
  input  logic [W-1:0] D_valC,
  input  logic [W-1:0] D_valP,
  input  logic [3:0]   e_dstE,
  input  logic [W-1:0] e_valE,
  input  logic [3:0]   M_dstE,
  input  logic [3:0]   M_dstM,
  input  logic [W-1:0] M_valE,
  input  logic [W-1:0] m_valM,
  input  logic [3:0]   W_dstE,
  input  logic [3:0]   W_dstM,
  input  logic [W-1:0] W_valE,
  input  logic [W-1:0] W_valM,
  input  logic         E_stall,
  input  logic         E_bubble,
  output logic [3:0]   d_srcA,
  output logic [3:0]   d_srcB,
  output logic [1:0]   E_stat,
  output logic [3:0]   E_icode,
  output logic [3:0]   E_ifun,
  output logic [W-1:0] E_valC,
  output logic [W-1:0] E_valA,
  output logic [W-1:0] E_valB,
  output logic [3:0]   E_dstE,
  output logic [3:0]   E_dstM,
  output logic [3:0]   E_srcA,
  output logic [3:0]   E_srcB
);
  logic [3:0]   src_a_d, src_b_d, dst_e_d, dst_m_d;
  logic [W-1:0] rf_a, rf_b, val_a_d, val_b_d;
  logic [1:0]   e_stat_q;
  logic [3:0]   e_icode_q, e_ifun_q, e_dste_q, e_dstm_q, e_srca_q, e_srcb_q;
  logic [W-1:0] e_valc_q, e_vala_q, e_valb_q;
  assign src_a_d = (D_icode inside {IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ}) ? D_rA :
                   (D_icode inside {IPOPQ, IRET}) ? RSP_ID : RNONE;
  assign src_b_d = (D_icode inside {IRMMOVQ, IMRMOVQ, IOPQ}) ? D_rB :
                   (D_icode inside {IPUSHQ, IPOPQ, ICALL, IRET}) ? RSP_ID : RNONE;
  assign dst_e_d = (D_icode inside {IRRMOVQ, IIRMOVQ, IOPQ}) ? D_rB :
                   (D_icode inside {IPUSHQ, IPOPQ, ICALL, IRET}) ? RSP_ID : RNONE;
  assign dst_m_d = (D_icode inside {IMRMOVQ, IPOPQ}) ? D_rA : RNONE;
  assign d_srcA = src_a_d;
  assign d_srcB = src_b_d;
  y86_regfile #(.W(W), .NREG(NREG)) u_rf (
    .clock(clock), .reset_n(reset_n),
    .src_a(src_a_d), .src_b(src_b_d), .val_a(rf_a), .val_b(rf_b),
    .dst_e(W_dstE), .dst_m(W_dstM), .val_e(W_valE), .val_m(W_valM)
  );
  // Youngest producer wins; RNONE sources never match and fall through to the zero read
  function automatic logic [W-1:0] fwd(input logic [3:0] s, input logic [W-1:0] rf);
    return (!FWD_EN || s == RNONE) ? rf :
           s == e_dstE ? e_valE :
           s == M_dstM ? m_valM :
           s == M_dstE ? M_valE :
           s == W_dstM ? W_valM :
           s == W_dstE ? W_valE : rf;
  endfunction
  assign val_a_d = (D_icode inside {ICALL, IJXX}) ? D_valP : fwd(src_a_d, rf_a);
  assign val_b_d = fwd(src_b_d, rf_b);
  always_ff @(posedge clock) begin
    if (!reset_n || E_bubble) begin
      e_stat_q  <= SAOK;
      e_icode_q <= INOP;
      e_ifun_q  <= 4'h0;
      e_valc_q  <= '0;
      e_vala_q  <= '0;
      e_valb_q  <= '0;
      e_dste_q  <= RNONE;
      e_dstm_q  <= RNONE;
      e_srca_q  <= RNONE;
      e_srcb_q  <= RNONE;
    end else if (!E_stall) begin
      e_stat_q  <= D_stat;
      e_icode_q <= D_icode;
      e_ifun_q  <= D_ifun;
      e_valc_q  <= D_valC;
      e_vala_q  <= val_a_d;
      e_valb_q  <= val_b_d;
      e_dste_q  <= dst_e_d;
      e_dstm_q  <= dst_m_d;
      e_srca_q  <= src_a_d;
      e_srcb_q  <= src_b_d;
    end
  end
  assign E_stat  = e_stat_q;
  assign E_icode = e_icode_q;
  assign E_ifun  = e_ifun_q;
  assign E_valC  = e_valc_q;
  assign E_valA  = e_vala_q;
  assign E_valB  = e_valb_q;
  assign E_dstE  = e_dste_q;
  assign E_dstM  = e_dstm_q;
  assign E_srcA  = e_srca_q;
  assign E_srcB  = e_srcb_q;
endmodule

// File: tb/tb_y86_decode_stage.sv
// tb_y86_decode_stage: directed and random checks of decode, forwarding, register file and E register.
module tb_y86_decode_stage;
  logic clock = 1'b0, reset_n;
  logic [1:0] D_stat;
  logic [3:0] D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0] e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic E_stall, E_bubble;
  logic [3:0] d_srcA, d_srcB, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [1:0] E_stat;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0] nf_srcA, nf_srcB, nf_icode, nf_ifun, nf_dstE, nf_dstM, nf_E_srcA, nf_E_srcB;
  logic [1:0] nf_stat;
  logic [63:0] nf_valC, nf_valA, nf_valB;

  y86_decode_stage dut (
    .clock(clock), .reset_n(reset_n), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM), .W_dstE(W_dstE),
    .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM), .E_stall(E_stall), .E_bubble(E_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB)
  );
  y86_decode_stage #(.FWD_EN(1'b0)) dut_nf (
    .clock(clock), .reset_n(reset_n), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM), .W_dstE(W_dstE),
    .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM), .E_stall(E_stall), .E_bubble(E_bubble),
    .d_srcA(nf_srcA), .d_srcB(nf_srcB), .E_stat(nf_stat), .E_icode(nf_icode), .E_ifun(nf_ifun),
    .E_valC(nf_valC), .E_valA(nf_valA), .E_valB(nf_valB), .E_dstE(nf_dstE), .E_dstM(nf_dstM),
    .E_srcA(nf_E_srcA), .E_srcB(nf_E_srcB)
  );

  always #5 clock = ~clock;

  // Per-icode field source: 0 = none, 1 = rA, 2 = rB, 3 = stack pointer
  int sa_t[16] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 3, 1, 3, 0, 0, 0, 0};
  int sb_t[16] = '{0, 0, 0, 0, 2, 2, 2, 0, 3, 3, 3, 3, 0, 0, 0, 0};
  int de_t[16] = '{0, 0, 2, 2, 0, 0, 2, 0, 3, 3, 3, 3, 0, 0, 0, 0};
  int dm_t[16] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  logic [63:0] rf [15];
  logic [1:0] x_stat;
  logic [3:0] x_icode, x_ifun, x_dstE, x_dstM, x_srcA, x_srcB;
  logic [63:0] x_valC, x_valA, x_valB, x_nfA, x_nfB;
  int n_cmp = 0, n_bad = 0;

  function automatic logic [3:0] pick(int code, logic [3:0] ra, logic [3:0] rb);
    return code == 1 ? ra : code == 2 ? rb : code == 3 ? 4'h4 : 4'hF;
  endfunction

  function automatic logic [63:0] rd(logic [3:0] id);
    return id == 4'hF ? 64'd0 : rf[id];
  endfunction

  function automatic logic [63:0] fwd(logic [3:0] s);
    logic [3:0] d[5];
    logic [63:0] v[5];
    d[0] = e_dstE; v[0] = e_valE;
    d[1] = M_dstM; v[1] = m_valM;
    d[2] = M_dstE; v[2] = M_valE;
    d[3] = W_dstM; v[3] = W_valM;
    d[4] = W_dstE; v[4] = W_valE;
    if (s == 4'hF) return 64'd0;
    for (int i = 0; i < 5; i++) if (d[i] == s) return v[i];
    return rd(s);
  endfunction

  function automatic logic [3:0] rid();
    int r = $urandom_range(0, 6);
    return r == 6 ? 4'hF : 4'(r);
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic bubble_exp();
    x_stat = 2'd0; x_icode = 4'h1; x_ifun = 4'h0;
    x_valC = 0; x_valA = 0; x_valB = 0; x_nfA = 0; x_nfB = 0;
    x_dstE = 4'hF; x_dstM = 4'hF; x_srcA = 4'hF; x_srcB = 4'hF;
  endtask

  task automatic step();
    logic [3:0] sa, sb;
    logic pc;
    #1;
    sa = pick(sa_t[D_icode], D_rA, D_rB);
    sb = pick(sb_t[D_icode], D_rA, D_rB);
    chk("d_srcA", {60'd0, d_srcA}, {60'd0, sa});
    chk("d_srcB", {60'd0, d_srcB}, {60'd0, sb});
    pc = (D_icode == 4'h8 || D_icode == 4'h7);
    @(posedge clock);
    if (!reset_n || E_bubble) bubble_exp();
    else if (!E_stall) begin
      x_stat = D_stat; x_icode = D_icode; x_ifun = D_ifun; x_valC = D_valC;
      x_valA = pc ? D_valP : fwd(sa); x_valB = fwd(sb);
      x_nfA = pc ? D_valP : rd(sa); x_nfB = rd(sb);
      x_dstE = pick(de_t[D_icode], D_rA, D_rB); x_dstM = pick(dm_t[D_icode], D_rA, D_rB);
      x_srcA = sa; x_srcB = sb;
    end
    if (!reset_n) for (int i = 0; i < 15; i++) rf[i] = 64'd0;
    else begin
      if (W_dstE != 4'hF) rf[W_dstE] = W_valE;
      if (W_dstM != 4'hF) rf[W_dstM] = W_valM;
    end
    #1;
    chk("E_stat", {62'd0, E_stat}, {62'd0, x_stat});
    chk("E_icode", {60'd0, E_icode}, {60'd0, x_icode});
    chk("E_ifun", {60'd0, E_ifun}, {60'd0, x_ifun});
    chk("E_valC", E_valC, x_valC);
    chk("E_valA", E_valA, x_valA);
    chk("E_valB", E_valB, x_valB);
    chk("E_dstE", {60'd0, E_dstE}, {60'd0, x_dstE});
    chk("E_dstM", {60'd0, E_dstM}, {60'd0, x_dstM});
    chk("E_srcA", {60'd0, E_srcA}, {60'd0, x_srcA});
    chk("E_srcB", {60'd0, E_srcB}, {60'd0, x_srcB});
    chk("nf_valA", nf_valA, x_nfA);
    chk("nf_valB", nf_valB, x_nfB);
  endtask

  task automatic idle();
    reset_n = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
    D_stat = 2'd0; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
    D_valC = 0; D_valP = 0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
  endtask

  task automatic rnd_d();
    D_stat = 2'($urandom_range(0, 3)); D_icode = 4'($urandom_range(0, 15));
    D_ifun = 4'($urandom_range(0, 15)); D_rA = rid(); D_rB = rid();
    D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2; W_dstE = 4'h3; W_valE = 64'h55;
    step();
    step();
    chk("rst_icode", {60'd0, E_icode}, 64'd1);
    chk("rst_dstE", {60'd0, E_dstE}, 64'hF);
    chk("rst_valA", E_valA, 64'd0);
    idle();
    for (int r = 0; r < 15; r++) begin
      D_icode = 4'h6; D_rA = 4'(r); D_rB = 4'(r);
      step();
      chk("rst_reg", E_valA, 64'd0);
    end
    // Write-back forwarded in the same cycle, then read from the register file
    idle();
    W_dstE = 4'h2; W_valE = 64'h2A382812;
    D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h7;
    step();
    chk("wb_fwd_valA", E_valA, 64'h2A382812);
    chk("wb_fwd_dstE", {60'd0, E_dstE}, 64'd7);
    W_dstE = 4'hF;
    step();
    chk("rf_read_valA", E_valA, 64'h2A382812);
    idle();
    D_icode = 4'h2; D_rA = 4'h3;
    e_dstE = 4'h3; e_valE = 64'h11; M_dstM = 4'h3; m_valM = 64'h22; W_dstE = 4'h3; W_valE = 64'h33;
    step();
    chk("prio_e", E_valA, 64'h11);
    e_dstE = 4'hF;
    step();
    chk("prio_m", E_valA, 64'h22);
    chk("nofwd_rf", nf_valA, 64'h33);
    idle();
    W_dstE = 4'h4; W_valE = 64'h100;
    step();
    idle();
    D_icode = 4'hB; D_rA = 4'h5;
    step();
    chk("pop_dstE", {60'd0, E_dstE}, 64'd4);
    chk("pop_dstM", {60'd0, E_dstM}, 64'd5);
    chk("pop_valA", E_valA, 64'h100);
    D_icode = 4'h8; D_valP = 64'h40;
    step();
    chk("call_valA", E_valA, 64'h40);
    chk("call_dstE", {60'd0, E_dstE}, 64'd4);
    idle();
    D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2; D_valC = 64'h1234;
    step();
    E_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_d();
      step();
    end
    chk("stall_icode", {60'd0, E_icode}, 64'd6);
    chk("stall_valC", E_valC, 64'h1234);
    E_bubble = 1'b1;
    step();
    chk("stall_bubble", {60'd0, E_icode}, 64'd1);
    idle();
    W_dstE = 4'h1; W_dstM = 4'h1; W_valE = 64'hAA; W_valM = 64'hBB;
    step();
    idle();
    D_icode = 4'h6; D_rA = 4'h1;
    step();
    chk("dual_write", E_valA, 64'hBB);
    for (int n = 0; n < 2000; n++) begin
      rnd_d();
      e_dstE = rid(); M_dstE = rid(); M_dstM = rid(); W_dstE = rid(); W_dstM = rid();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
      W_valE = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
      E_stall = ($urandom_range(0, 4) == 0);
      E_bubble = ($urandom_range(0, 9) == 0);
      reset_n = ($urandom_range(0, 39) != 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
